minimig_autoconfig_host: RTL and testbench



---
 rtl/minimig_autoconfig_host.sv | 178 +++++++++++++++++
 tb/tb_minimig_autoconfig_host.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/minimig_autoconfig_host.sv
// Host-side AutoConfig initiator: walks the $E8xxxx chain and reads each board's type.
// It allocates an aligned Z2/Z3 base and commits it at $48, or shuts the board up at $4C.
module minimig_autoconfig_host #(
    parameter int         MAX_BOARDS = 4,
    parameter logic [7:0]  Z2_BASE   = 8'h20,
    parameter logic [8:0]  Z2_LIMIT  = 9'h0A0,
    parameter logic [15:0] Z3_BASE   = 16'h4000,
    parameter logic [16:0] Z3_LIMIT  = 17'h08000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        start,
    output logic [6:0]  address_out,
    output logic [15:0] data_out,
    input  logic [15:0] data_in,
    output logic        rd,
    output logic        hwr,
    output logic        lwr,
    output logic        sel,
    output logic        busy,
    output logic        done,
    output logic        cfg_valid,
    output logic        cfg_z3,
    output logic        cfg_shutup,
    output logic [15:0] cfg_base,
    output logic [2:0]  cfg_size,
    output logic [2:0]  boards_found
);
    localparam int CW = $clog2(MAX_BOARDS + 1);

    typedef enum logic [3:0] {IDLE, RD_HI, RD_LO, DECODE, WR_LO, WR_HI, SHUTUP, REPORT, DONE} state_t;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
        logic        rd;
        logic        hwr;
        logic        lwr;
        logic        sel;
    } bus_t;

    state_t        state, state_n, tgt;
    logic [1:0]    phase, phase_n;
    bus_t          bus_q, bus_n;
    logic [7:0]    type_r, type_n;
    logic [8:0]    z2_next, z2_n;
    logic [16:0]   z3_next, z3_n;
    logic [15:0]   base_r, base_n;
    logic          z3_sel, z3_sel_n, shut, shut_n, go;
    logic [CW-1:0] board_cnt, cnt_n;
    logic [2:0]    found_n, csize_n;
    logic          busy_n, done_n, valid_n, cz3_n, cshut_n;
    logic [15:0]   cbase_n;

    // Size in 64K units and the aligned placement in each pool.
    logic [16:0] sz, z3_al, z3_end;
    logic [8:0]  z2_al, z2_end;
    assign sz     = (type_r[2:0] == 3'd0) ? 17'd128 : (17'd1 << (type_r[2:0] - 3'd1));
    assign z2_al  = (z2_next + sz[8:0] - 9'd1) & ~(sz[8:0] - 9'd1);
    assign z2_end = z2_al + sz[8:0];
    assign z3_al  = (z3_next + sz - 17'd1) & ~(sz - 17'd1);
    assign z3_end = z3_al + sz;

    logic unused_bits;
    assign unused_bits = &{1'b0, data_in[11:0], type_r[5:3]};

    function automatic bus_t bus_for(input state_t s, input logic z3, input logic [15:0] b);
        bus_t r;
        r = '0;
        r.sel = 1'b1;
        case (s)
            RD_HI:  r.rd = 1'b1;
            RD_LO:  begin r.addr = 7'h01; r.rd = 1'b1; end
            WR_LO: begin
                r.hwr = 1'b1;
                if (z3) begin r.addr = 7'h22; r.data = b; r.lwr = 1'b1; end
                else begin r.addr = 7'h25; r.data = {b[3:0], 12'h000}; end
            end
            WR_HI: begin
                r.addr = 7'h24; r.hwr = 1'b1;
                r.data = z3 ? {b[15:12], 12'h000} : {b[7:4], 12'h000};
            end
            SHUTUP: begin r.addr = 7'h26; r.hwr = 1'b1; end
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_n = state; phase_n = phase; bus_n = bus_q;
        type_n = type_r; z2_n = z2_next; z3_n = z3_next; base_n = base_r;
        z3_sel_n = z3_sel; shut_n = shut; cnt_n = board_cnt; found_n = boards_found;
        busy_n = busy; done_n = 1'b0; valid_n = 1'b0;
        cz3_n = cfg_z3; cshut_n = cfg_shutup; cbase_n = cfg_base; csize_n = cfg_size;
        go = 1'b0; tgt = IDLE;
        case (state)
            IDLE: if (start && !done) begin
                z2_n = {1'b0, Z2_BASE}; z3_n = {1'b0, Z3_BASE};
                cnt_n = '0; found_n = 3'd0; busy_n = 1'b1;
                go = 1'b1; tgt = RD_HI;
            end
            RD_HI, RD_LO, WR_LO, WR_HI, SHUTUP: if (clk7_en) begin
                if (phase == 2'd0) begin
                    bus_n = bus_for(state, z3_sel, base_r);
                    phase_n = 2'd1;
                end else if ((state == RD_HI || state == RD_LO) && phase == 2'd1) begin
                    phase_n = 2'd2;
                end else begin
                    // Access ends this tick; chained accesses start on the same tick.
                    bus_n.rd = 1'b0; bus_n.hwr = 1'b0; bus_n.lwr = 1'b0; bus_n.sel = 1'b0;
                    phase_n = 2'd0;
                    case (state)
                        RD_HI: begin
                            type_n[7:4] = data_in[15:12];
                            state_n = RD_LO; bus_n = bus_for(RD_LO, z3_sel, base_r); phase_n = 2'd1;
                        end
                        RD_LO: begin type_n[3:0] = data_in[15:12]; state_n = DECODE; end
                        WR_LO: begin state_n = WR_HI; bus_n = bus_for(WR_HI, z3_sel, base_r); phase_n = 2'd1; end
                        WR_HI: begin found_n = boards_found + 3'd1; state_n = REPORT; end
                        default: state_n = REPORT;
                    endcase
                end
            end
            DECODE: if (!type_r[7]) begin
                state_n = DONE;
            end else begin
                z3_sel_n = !type_r[6];
                if (z3_sel_n) begin
                    shut_n = z3_end > Z3_LIMIT; base_n = z3_al[15:0];
                    if (!shut_n) z3_n = z3_end;
                end else begin
                    shut_n = z2_end > Z2_LIMIT; base_n = {7'd0, z2_al};
                    if (!shut_n) z2_n = z2_end;
                end
                go = 1'b1; tgt = shut_n ? SHUTUP : WR_LO;
            end
            REPORT: begin
                valid_n = 1'b1; cz3_n = z3_sel; cshut_n = shut;
                cbase_n = shut ? 16'h0000 : base_r; csize_n = type_r[2:0];
                cnt_n = board_cnt + 1'b1;
                if (cnt_n == CW'(MAX_BOARDS)) state_n = DONE;
                else begin go = 1'b1; tgt = RD_HI; end
            end
            DONE: begin done_n = 1'b1; busy_n = 1'b0; state_n = IDLE; end
            default: state_n = IDLE;
        endcase
        // Entering an access off-tick waits for the next tick to drive the bus.
        if (go) begin
            state_n = tgt;
            if (clk7_en) begin bus_n = bus_for(tgt, z3_sel_n, base_n); phase_n = 2'd1; end
            else phase_n = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE; phase <= 2'd0; bus_q <= '0;
            type_r <= 8'h00; z2_next <= 9'd0; z3_next <= 17'd0; base_r <= 16'h0000;
            z3_sel <= 1'b0; shut <= 1'b0; board_cnt <= '0; boards_found <= 3'd0;
            busy <= 1'b0; done <= 1'b0; cfg_valid <= 1'b0;
            cfg_z3 <= 1'b0; cfg_shutup <= 1'b0; cfg_base <= 16'h0000; cfg_size <= 3'd0;
        end else begin
            state <= state_n; phase <= phase_n; bus_q <= bus_n;
            type_r <= type_n; z2_next <= z2_n; z3_next <= z3_n; base_r <= base_n;
            z3_sel <= z3_sel_n; shut <= shut_n; board_cnt <= cnt_n; boards_found <= found_n;
            busy <= busy_n; done <= done_n; cfg_valid <= valid_n;
            cfg_z3 <= cz3_n; cfg_shutup <= cshut_n; cfg_base <= cbase_n; cfg_size <= csize_n;
        end
    end

    assign address_out = bus_q.addr;
    assign data_out    = bus_q.data;
    assign rd          = bus_q.rd;
    assign hwr         = bus_q.hwr;
    assign lwr         = bus_q.lwr;
    assign sel         = bus_q.sel;
endmodule

// File: tb/tb_minimig_autoconfig_host.sv
// Bench for minimig_autoconfig_host: a board-chain responder plus an allocation model
// derived from the AutoConfig rules, with randomized chains and bus-tick pacing.
module tb_minimig_autoconfig_host;
    localparam int MAXB = 4;

    logic        clk, reset, clk7_en, start;
    logic [6:0]  address_out;
    logic [15:0] data_out, data_in, cfg_base;
    logic        rd, hwr, lwr, sel, busy, done, cfg_valid, cfg_z3, cfg_shutup;
    logic [2:0]  cfg_size, boards_found;

    minimig_autoconfig_host dut (
        .clk(clk), .reset(reset), .clk7_en(clk7_en), .start(start),
        .address_out(address_out), .data_out(data_out), .data_in(data_in),
        .rd(rd), .hwr(hwr), .lwr(lwr), .sel(sel), .busy(busy), .done(done),
        .cfg_valid(cfg_valid), .cfg_z3(cfg_z3), .cfg_shutup(cfg_shutup),
        .cfg_base(cfg_base), .cfg_size(cfg_size), .boards_found(boards_found)
    );

    int checks = 0;
    int errors = 0;

    // Responder: board k of the chain is visible until it is committed or shut up.
    logic [7:0] resp_types [0:15];
    int         resp_n = 0;
    int         resp_off = 0;
    int         resp_idx = 0;
    logic [7:0] cur_t;
    int         cur_k;
    assign cur_k  = resp_idx - resp_off;
    assign cur_t  = (cur_k < resp_n) ? resp_types[cur_k[3:0]] : 8'h00;
    assign data_in = (sel && rd) ?
        ((address_out == 7'h00) ? {cur_t[7:4], 12'h5A3} :
         (address_out == 7'h01) ? {cur_t[3:0], 12'h5A3} : 16'h0000) : 16'h0000;

    initial begin clk = 1'b0; forever #5 clk = ~clk; end

    initial begin
        int gap;
        gap = 0; clk7_en = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (gap == 0) begin clk7_en = 1'b1; gap = $urandom_range(0, 3); end
            else begin clk7_en = 1'b0; gap--; end
        end
    end

    // Bus monitor, sampled mid-cycle: what the responder sees at each tick.
    logic [24:0] wr_log [$];
    logic [20:0] rep_log [$];
    int          reads = 0, done_cnt = 0, bus_viol = 0;
    logic        last_rd = 1'b0, prev_tick = 1'b0, prev_rst = 1'b1;
    logic [6:0]  last_addr = 7'h00;
    logic [26:0] bus_now, prev_bus = '0;
    assign bus_now = {address_out, data_out, rd, hwr, lwr, sel};

    always @(negedge clk) begin
        if (!prev_rst && !prev_tick && bus_now !== prev_bus) bus_viol <= bus_viol + 1;
        if (!reset) begin
            if (clk7_en) begin
                if (rd && sel && (!last_rd || address_out != last_addr)) reads <= reads + 1;
                if (sel && (hwr || lwr)) begin
                    wr_log.push_back({address_out, data_out, hwr, lwr});
                    if (hwr && (address_out == 7'h24 || address_out == 7'h26)) resp_idx <= resp_idx + 1;
                end
                last_rd <= rd && sel; last_addr <= address_out;
            end
            if (cfg_valid) rep_log.push_back({cfg_z3, cfg_shutup, cfg_base, cfg_size});
            if (done) done_cnt <= done_cnt + 1;
        end
        prev_bus <= bus_now; prev_tick <= clk7_en; prev_rst <= reset;
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({rd, hwr, lwr, sel} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b want 0000", {rd, hwr, lwr, sel}); end
        checks++; if ({busy, done, cfg_valid, cfg_z3, cfg_shutup} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {busy, done, cfg_valid, cfg_z3, cfg_shutup}); end
        checks++; if ({address_out, data_out} !== 23'h0) begin errors++; $display("FAIL reset_bus got %h/%h want 0/0", address_out, data_out); end
        checks++; if ({cfg_base, cfg_size, boards_found} !== 22'h0) begin errors++; $display("FAIL reset_cfg got %h %0d %0d want 0", cfg_base, cfg_size, boards_found); end
        @(negedge clk); reset = 1'b0;
    endtask

    // One full scan of the chain loaded in resp_types, compared against the rule model.
    task automatic test_scan(input string name);
        logic [24:0] ew [$];
        logic [20:0] er [$];
        int z2, z3, size, base, nfound, nreads, w0, r0, rd0, d0;
        logic [7:0] t;
        bit z3b, shut, got;
        z2 = 'h20; z3 = 'h4000; nfound = 0; nreads = 0;
        for (int i = 0; i < MAXB; i++) begin
            t = (i < resp_n) ? resp_types[i] : 8'h00;
            nreads += 2;
            if (t[7:6] != 2'b11 && t[7:6] != 2'b10) break;
            z3b  = (t[7:6] == 2'b10);
            size = (t[2:0] == 3'd0) ? 128 : (1 << (t[2:0] - 1));
            base = z3b ? ((z3 + size - 1) / size) * size : ((z2 + size - 1) / size) * size;
            shut = z3b ? (base + size > 'h8000) : (base + size > 'hA0);
            if (shut) ew.push_back({7'h26, 16'h0000, 2'b10});
            else begin
                nfound++;
                if (z3b) begin
                    ew.push_back({7'h22, 16'(base), 2'b11});
                    ew.push_back({7'h24, 16'(((base >> 12) & 15) << 12), 2'b10});
                    z3 = base + size;
                end else begin
                    ew.push_back({7'h25, 16'((base % 16) << 12), 2'b10});
                    ew.push_back({7'h24, 16'(((base / 16) % 16) << 12), 2'b10});
                    z2 = base + size;
                end
            end
            er.push_back({z3b, shut, shut ? 16'h0000 : 16'(base), t[2:0]});
        end
        resp_off = resp_idx;
        w0 = wr_log.size(); r0 = rep_log.size(); rd0 = reads; d0 = done_cnt;
        pulse_start();
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin @(negedge clk); if (done) got = 1; end
        checks++; if (!got) begin errors++; $display("FAIL %s done_timeout got none want pulse", name); end
        repeat (10) @(negedge clk);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", name, done_cnt - d0); end
        checks++; if (reads - rd0 != nreads) begin errors++; $display("FAIL %s reads got %0d want %0d", name, reads - rd0, nreads); end
        checks++;
        if (wr_log.size() - w0 != ew.size()) begin errors++; $display("FAIL %s write_count got %0d want %0d", name, wr_log.size() - w0, ew.size()); end
        else foreach (ew[i]) if (wr_log[w0 + i] !== ew[i]) begin
            errors++; $display("FAIL %s write[%0d] got %h want %h", name, i, wr_log[w0 + i], ew[i]);
        end
        checks++;
        if (rep_log.size() - r0 != er.size()) begin errors++; $display("FAIL %s report_count got %0d want %0d", name, rep_log.size() - r0, er.size()); end
        else foreach (er[i]) if (rep_log[r0 + i] !== er[i]) begin
            errors++; $display("FAIL %s report[%0d] got %h want %h", name, i, rep_log[r0 + i], er[i]);
        end
        checks++; if (boards_found !== 3'(nfound)) begin errors++; $display("FAIL %s boards_found got %0d want %0d", name, boards_found, nfound); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after got %b want 0", name, busy); end
        if (er.size() > 0) begin
            checks++; if (cfg_base !== er[er.size() - 1][18:3]) begin errors++; $display("FAIL %s cfg_hold got %h want %h", name, cfg_base, er[er.size() - 1][18:3]); end
        end
        checks++; if (bus_viol != 0) begin errors++; $display("FAIL %s offtick_changes got %0d want 0", name, bus_viol); end
    endtask

    task automatic test_directed();
        resp_n = 1; resp_types[0] = 8'hE6; test_scan("z2_single");
        resp_n = 2; resp_types[0] = 8'hE1; resp_types[1] = 8'hE7; test_scan("z2_align");
        resp_n = 3; resp_types[0] = 8'hE7; resp_types[1] = 8'hE6; resp_types[2] = 8'hE1; test_scan("z2_exact_fill");
        resp_n = 2; resp_types[0] = 8'hE0; resp_types[1] = 8'hE5; test_scan("z2_8mb");
        resp_n = 1; resp_types[0] = 8'hA0; test_scan("z3_8mb");
        resp_n = 5; for (int i = 0; i < 5; i++) resp_types[i] = 8'hE6; test_scan("max_boards");
    endtask

    task automatic test_start_hold();
        int rd0, w0, d0;
        bit got;
        resp_n = 1; resp_types[0] = 8'hE6; resp_off = resp_idx;
        rd0 = reads; w0 = wr_log.size(); d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin @(negedge clk); if (done) got = 1; end
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (!got) begin errors++; $display("FAIL hold done_timeout got none want pulse"); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL hold done_pulses got %0d want 1", done_cnt - d0); end
        checks++; if (reads - rd0 != 4) begin errors++; $display("FAIL hold reads got %0d want 4", reads - rd0); end
        checks++; if (wr_log.size() - w0 != 2) begin errors++; $display("FAIL hold writes got %0d want 2", wr_log.size() - w0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit got;
        resp_n = 2; resp_types[0] = 8'hE6; resp_types[1] = 8'hE6; resp_off = resp_idx;
        pulse_start();
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin @(negedge clk); if (hwr && sel && address_out == 7'h24) got = 1; end
        checks++; if (!got) begin errors++; $display("FAIL rst_mid commit_timeout got none want $48 write"); end
        reset = 1'b1;
        @(posedge clk); #1;
        d0 = done_cnt;
        checks++; if ({rd, hwr, lwr, sel, busy} !== 5'b0) begin errors++; $display("FAIL rst_mid outputs got %b want 00000", {rd, hwr, lwr, sel, busy}); end
        @(negedge clk); reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (done_cnt != d0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid idle got done %0d busy %b want 0 0", done_cnt - d0, busy); end
        test_scan("rescan");
    endtask

    task automatic test_random();
        int c;
        for (int s = 0; s < 8; s++) begin
            resp_n = $urandom_range(1, 6);
            for (int i = 0; i < resp_n; i++) begin
                c = $urandom_range(0, 9);
                resp_types[i] = {(c == 0) ? 2'($urandom_range(0, 1)) : (c < 4) ? 2'b10 : 2'b11, 6'($urandom)};
            end
            test_scan("random");
        end
    endtask

    initial begin
        start = 1'b0; reset = 1'b1;
        test_reset();
        test_directed();
        test_start_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
